// File: rtl/gbe_tx_packetizer.sv
// rtl/gbe_tx_packetizer.sv - buffers a 64-bit sample stream and frames it (header + payload) for the 10GbE tx core
module gbe_tx_packetizer #(
  parameter int PKT_WORDS  = 128,
  parameter int FIFO_AW    = 9,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sync_in,
  input  logic        din_valid,
  input  logic [63:0] din,
  input  logic [15:0] hdr_id,
  input  logic [31:0] dest_ip_in,
  input  logic [15:0] dest_port_in,
  input  logic        tx_afull,
  input  logic        tx_overflow,
  output logic        tx_valid,
  output logic        tx_end_of_frame,
  output logic [63:0] tx_data,
  output logic [31:0] tx_dest_ip,
  output logic [15:0] tx_dest_port,
  output logic        fifo_overflow,
  output logic [31:0] drop_cnt,
  output logic [15:0] core_ovf_cnt,
  output logic [31:0] pkt_sent_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int AW1   = FIFO_AW + 1;
  localparam int WC_W  = $clog2(PKT_WORDS);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [FIFO_AW:0] FULL_OCC = AW1'(DEPTH);
  localparam logic [FIFO_AW:0] PKT_OCC  = AW1'(PKT_WORDS);
  localparam logic [WC_W-1:0]  LAST_WC  = WC_W'(PKT_WORDS - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t             state_q;
  logic [WC_W-1:0]    word_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               tx_valid_q;
  logic               tx_eof_q;
  logic [63:0]        tx_data_q;
  logic [31:0]        tx_dest_ip_q;
  logic [15:0]        tx_dest_port_q;

  logic [63:0]        mem_q [DEPTH];
  logic [FIFO_AW:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   occ;
  logic               fifo_full;
  logic               wr_en;
  logic               rd_en;

  logic [47:0]        pkt_cnt_q, pkt_cnt_d;
  logic               sync_pend_q, sync_pend_d;
  logic [47:0]        hdr_cnt;
  logic               hdr_fire;
  logic               frame_end;

  logic               fifo_ovf_q, fifo_ovf_d;
  logic [31:0]        drop_cnt_q, drop_cnt_d;
  logic [15:0]        core_ovf_q, core_ovf_d;
  logic [31:0]        pkt_sent_q, pkt_sent_d;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign occ       = wr_ptr_q - rd_ptr_q;
  assign fifo_full = (occ == FULL_OCC);
  assign wr_en     = din_valid && !fifo_full;
  assign rd_en     = (state_q == ST_PAY) && !tx_afull;

  assign hdr_fire  = (state_q == ST_HDR) && !tx_afull;
  assign frame_end = rd_en && (word_cnt_q == LAST_WC);
  assign hdr_cnt   = sync_in ? 48'd0 : pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      word_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      tx_valid_q     <= 1'b0;
      tx_eof_q       <= 1'b0;
      tx_data_q      <= '0;
      tx_dest_ip_q   <= '0;
      tx_dest_port_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_valid_q <= 1'b0;
          tx_eof_q   <= 1'b0;
          if (enable && (occ >= PKT_OCC) && !tx_afull) begin
            state_q        <= ST_HDR;
            tx_dest_ip_q   <= dest_ip_in;
            tx_dest_port_q <= dest_port_in;
          end
        end
        ST_HDR: begin
          tx_eof_q <= 1'b0;
          if (!tx_afull) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= {hdr_id, hdr_cnt};
            word_cnt_q <= '0;
            state_q    <= ST_PAY;
          end else begin
            tx_valid_q <= 1'b0;
          end
        end
        ST_PAY: begin
          // Stalling on tx_afull keeps the word counter and FIFO read pointer frozen.
          if (!tx_afull) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= mem_q[rd_ptr_q[FIFO_AW-1:0]];
            word_cnt_q <= word_cnt_q + 1'b1;
            if (word_cnt_q == LAST_WC) begin
              tx_eof_q  <= 1'b1;
              gap_cnt_q <= '0;
              state_q   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end else begin
              tx_eof_q <= 1'b0;
            end
          end else begin
            tx_valid_q <= 1'b0;
            tx_eof_q   <= 1'b0;
          end
        end
        ST_GAP: begin
          tx_valid_q <= 1'b0;
          tx_eof_q   <= 1'b0;
          if (gap_cnt_q == LAST_GAP) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          tx_valid_q <= 1'b0;
          tx_eof_q   <= 1'b0;
        end
      endcase
    end
  end

  // A sync seen after a header has gone out must also cancel that frame's
  // end-of-frame increment, so it is remembered until the next header.
  always_comb begin
    pkt_cnt_d   = pkt_cnt_q;
    sync_pend_d = sync_pend_q;
    if (frame_end) begin
      pkt_cnt_d = sync_pend_q ? 48'd0 : pkt_cnt_q + 48'd1;
    end
    if (sync_in) begin
      pkt_cnt_d   = 48'd0;
      sync_pend_d = 1'b1;
    end
    if (hdr_fire) begin
      sync_pend_d = 1'b0;
    end
  end

  always_comb begin
    fifo_ovf_d = fifo_ovf_q;
    drop_cnt_d = drop_cnt_q;
    core_ovf_d = core_ovf_q;
    pkt_sent_d = pkt_sent_q;
    if (din_valid && fifo_full) begin
      fifo_ovf_d = 1'b1;
      if (drop_cnt_q != 32'hFFFF_FFFF) begin
        drop_cnt_d = drop_cnt_q + 32'd1;
      end
    end
    if (tx_overflow && (core_ovf_q != 16'hFFFF)) begin
      core_ovf_d = core_ovf_q + 16'd1;
    end
    if (frame_end) begin
      pkt_sent_d = pkt_sent_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt_q   <= '0;
      sync_pend_q <= 1'b0;
      fifo_ovf_q  <= 1'b0;
      drop_cnt_q  <= '0;
      core_ovf_q  <= '0;
      pkt_sent_q  <= '0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      sync_pend_q <= sync_pend_d;
      fifo_ovf_q  <= fifo_ovf_d;
      drop_cnt_q  <= drop_cnt_d;
      core_ovf_q  <= core_ovf_d;
      pkt_sent_q  <= pkt_sent_d;
    end
  end

  assign tx_valid        = tx_valid_q;
  assign tx_end_of_frame = tx_eof_q;
  assign tx_data         = tx_data_q;
  assign tx_dest_ip      = tx_dest_ip_q;
  assign tx_dest_port    = tx_dest_port_q;
  assign fifo_overflow   = fifo_ovf_q;
  assign drop_cnt        = drop_cnt_q;
  assign core_ovf_cnt    = core_ovf_q;
  assign pkt_sent_cnt    = pkt_sent_q;

endmodule

// File: tb/tb_gbe_tx_packetizer.sv
// tb/tb_gbe_tx_packetizer.sv - scoreboard bench for gbe_tx_packetizer
module tb_gbe_tx_packetizer;

  localparam int P     = 4;
  localparam int AW    = 3;
  localparam int GAP   = 4;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        sync_in;
  logic        din_valid;
  logic [63:0] din;
  logic [15:0] hdr_id;
  logic [31:0] dest_ip_in;
  logic [15:0] dest_port_in;
  logic        tx_afull;
  logic        tx_overflow;
  logic        tx_valid;
  logic        tx_end_of_frame;
  logic [63:0] tx_data;
  logic [31:0] tx_dest_ip;
  logic [15:0] tx_dest_port;
  logic        fifo_overflow;
  logic [31:0] drop_cnt;
  logic [15:0] core_ovf_cnt;
  logic [31:0] pkt_sent_cnt;

  gbe_tx_packetizer #(.PKT_WORDS(P), .FIFO_AW(AW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sync_in(sync_in),
    .din_valid(din_valid), .din(din), .hdr_id(hdr_id),
    .dest_ip_in(dest_ip_in), .dest_port_in(dest_port_in),
    .tx_afull(tx_afull), .tx_overflow(tx_overflow),
    .tx_valid(tx_valid), .tx_end_of_frame(tx_end_of_frame), .tx_data(tx_data),
    .tx_dest_ip(tx_dest_ip), .tx_dest_port(tx_dest_port),
    .fifo_overflow(fifo_overflow), .drop_cnt(drop_cnt),
    .core_ovf_cnt(core_ovf_cnt), .pkt_sent_cnt(pkt_sent_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        eof;
    logic [31:0] ip;
    logic [15:0] port;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  logic [63:0] m_fifo[$];
  logic [47:0] m_pkt_cnt = '0;
  int          m_held = 0;
  int          m_drops = 0;
  int          m_ovf = 0;
  logic [15:0] cur_hdr;
  logic [31:0] cur_ip;
  logic [15:0] cur_port;

  int checks = 0;
  int fails = 0;
  int beats_seen = 0;
  int cyc = 0;
  int eof_cyc = 0;
  bit eof_pending = 0;
  bit afull_prev = 0;
  bit rand_done = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference model: every PKT_WORDS accepted words make one frame, the
  // buffer holds DEPTH words while nothing drains it.
  function automatic void model_offer(logic [63:0] w);
    if (m_held >= DEPTH) begin
      m_drops++;
      return;
    end
    m_held++;
    m_fifo.push_back(w);
    if (m_fifo.size() == P) begin
      exp_q.push_back('{data: {cur_hdr, m_pkt_cnt}, eof: 1'b0, ip: cur_ip, port: cur_port});
      for (int i = 0; i < P; i++) begin
        exp_q.push_back('{data: m_fifo.pop_front(), eof: (i == P - 1), ip: cur_ip, port: cur_port});
      end
      m_pkt_cnt = m_pkt_cnt + 48'd1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(logic [63:0] w);
    din       = w;
    din_valid = 1'b1;
    model_offer(w);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic set_frame_inputs(logic [15:0] h, logic [31:0] ip, logic [15:0] port);
    cur_hdr      = h;
    cur_ip       = ip;
    cur_port     = port;
    hdr_id       = h;
    dest_ip_in   = ip;
    dest_port_in = port;
  endtask

  task automatic wait_beats(int target, int budget, string name);
    int n = 0;
    while (beats_seen < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (beats_seen < target) begin
      checks++;
      fails++;
      $display("FAIL %s: saw %0d beats, required %0d", name, beats_seen, target);
    end
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (GAP + 4) @(posedge clk);
    #1;
    m_held = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      afull_prev  = 0;
      eof_pending = 0;
    end else begin
      if (afull_prev) check("valid_after_afull", tx_valid, 0);
      if (tx_end_of_frame) check("eof_without_valid", tx_valid, 1);
      if (tx_valid) begin
        if (eof_pending) begin
          check("gap_too_short", (cyc - eof_cyc - 1 >= GAP), 1);
          eof_pending = 0;
        end
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_beat: got data 0x%0h, required no beat", tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("tx_data", tx_data, mon_e.data);
          check("tx_end_of_frame", tx_end_of_frame, mon_e.eof);
          check("tx_dest_ip", tx_dest_ip, mon_e.ip);
          check("tx_dest_port", tx_dest_port, mon_e.port);
        end
        beats_seen++;
        if (tx_end_of_frame) begin
          eof_pending = 1;
          eof_cyc     = cyc;
        end
      end
      afull_prev = tx_afull;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b0; enable = 1'b0; sync_in = 1'b0; din_valid = 1'b0; din = '0;
    tx_afull = 1'b0; tx_overflow = 1'b0;
    set_frame_inputs(16'h0, 32'h0, 16'h0);
    repeat (3) tick();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_eof", tx_end_of_frame, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_dest_ip", tx_dest_ip, 0);
    check("rst_dest_port", tx_dest_port, 0);
    check("rst_fifo_overflow", fifo_overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_core_ovf_cnt", core_ovf_cnt, 0);
    check("rst_pkt_sent_cnt", pkt_sent_cnt, 0);
    rst = 1'b1;
    tick();

    // Two back-to-back frames from 8 contiguous words
    set_frame_inputs(16'hA5A5, 32'hC0A8_0001, 16'd1234);
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) drive_word(64'(i));
    wait_drain(200);
    check("pkt_sent_after_two", pkt_sent_cnt, 2);

    // Back-pressure for 3 cycles in the middle of the payload
    base = beats_seen;
    fork
      for (int i = 9; i <= 16; i++) drive_word(64'(i));
      begin
        wait_beats(base + 3, 100, "afull_setup");
        tx_afull = 1'b1;
        repeat (3) tick();
        tx_afull = 1'b0;
      end
    join
    wait_drain(200);
    check("pkt_sent_after_afull", pkt_sent_cnt, 4);

    // Fill while disabled: depth 8, two words dropped
    enable = 1'b0;
    base = beats_seen;
    for (int i = 17; i <= 26; i++) drive_word(64'(i));
    repeat (3) tick();
    check("drop_cnt", drop_cnt, 64'(m_drops));
    check("fifo_overflow", fifo_overflow, 1);
    check("no_tx_while_disabled", 64'(beats_seen - base), 0);
    enable = 1'b1;
    wait_drain(200);
    check("pkt_sent_after_ovf", pkt_sent_cnt, 6);
    check("fifo_overflow_sticky", fifo_overflow, 1);

    // sync_in during a frame's payload: next header carries 0
    set_frame_inputs(16'h5A01, 32'h0A00_0002, 16'd4000);
    base = beats_seen;
    fork
      begin
        for (int i = 0; i < 4; i++) drive_word(64'hDEAD_0000 + 64'(i));
        m_pkt_cnt = '0;
        for (int i = 4; i < 8; i++) drive_word(64'hDEAD_0000 + 64'(i));
      end
      begin
        wait_beats(base + 2, 100, "sync_setup");
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
      end
    join
    wait_drain(200);
    check("pkt_sent_after_sync", pkt_sent_cnt, 8);

    // Core overflow pulses alongside a frame
    fork
      for (int i = 0; i < 4; i++) drive_word(64'hBEEF_0000 + 64'(i));
      for (int k = 0; k < 3; k++) begin
        tx_overflow = 1'b1;
        m_ovf++;
        tick();
        tx_overflow = 1'b0;
        tick();
      end
    join
    wait_drain(200);
    check("core_ovf_cnt", core_ovf_cnt, 64'(m_ovf));
    check("pkt_sent_after_ovfpulse", pkt_sent_cnt, 9);

    // Randomized frames with random back-pressure and overflow pulses
    fork
      begin
        while (!rand_done) begin
          tx_afull    = ($urandom_range(0, 4) == 0);
          tx_overflow = ($urandom_range(0, 15) == 0);
          if (tx_overflow) m_ovf++;
          tick();
        end
        tx_afull    = 1'b0;
        tx_overflow = 1'b0;
      end
      begin
        for (int f = 0; f < 16; f++) begin
          set_frame_inputs(16'($urandom), $urandom, 16'($urandom));
          base = beats_seen;
          for (int w = 0; w < P; w++) begin
            repeat ($urandom_range(0, 2)) tick();
            drive_word({$urandom, $urandom});
          end
          wait_beats(base + 1, 300, "rand_header");
          hdr_id       = 16'($urandom);
          dest_ip_in   = $urandom;
          dest_port_in = 16'($urandom);
          wait_drain(400);
        end
        rand_done = 1;
      end
    join
    tick();
    check("rand_core_ovf_cnt", core_ovf_cnt, 64'(m_ovf));
    check("rand_pkt_sent", pkt_sent_cnt, 25);
    check("rand_drop_cnt", drop_cnt, 64'(m_drops));

    // Asynchronous reset in the middle of a payload
    set_frame_inputs(16'h1234, 32'h0102_0304, 16'd80);
    base = beats_seen;
    for (int i = 0; i < P; i++) drive_word(64'h7700 + 64'(i));
    wait_beats(base + 3, 100, "reset_setup");
    #3;
    rst = 1'b0;
    exp_q.delete();
    m_fifo.delete();
    m_held = 0;
    m_pkt_cnt = '0;
    m_ovf = 0;
    #2;
    check("arst_tx_valid", tx_valid, 0);
    check("arst_tx_eof", tx_end_of_frame, 0);
    check("arst_pkt_sent", pkt_sent_cnt, 0);
    check("arst_drop_cnt", drop_cnt, 0);
    check("arst_core_ovf", core_ovf_cnt, 0);
    check("arst_fifo_overflow", fifo_overflow, 0);
    tick();
    rst = 1'b1;
    tick();
    base = beats_seen;
    for (int i = 0; i < P - 1; i++) drive_word(64'h9900 + 64'(i));
    repeat (20) tick();
    check("fifo_empty_after_reset", 64'(beats_seen - base), 0);
    drive_word(64'h9900 + 64'(P - 1));
    wait_drain(200);
    check("pkt_sent_after_reset", pkt_sent_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
